// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank
// Palette lookup for sprite pixel indices, with NUM_PAL banks that can be
// rewritten at run time. Each bank holds 2^INDEX_W colours of 3*CH_W bits.
// The lookup has a fixed latency of two cycles and accepts one pixel every
// cycle. A transparency flag travels alongside each pixel.
//
// Optional feature (macro SPRITE_PAL_HIT_FLASH_EN): a hit-flash FSM. While
// a flash is active, valid non-transparent pixels are forced to white. The
// flash lasts for flash_frames frame_tick pulses.
//
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   pix_valid, pal_sel, index          pixel lookup request
//   wr_en, wr_pal, wr_index, wr_rgb    palette entry write, {r,g,b}
//   frame_tick, flash_start, flash_frames   hit-flash control
//   red, green, blue    looked-up colour (holds while out_valid=0)
//   out_valid           colour outputs carry a pixel this cycle
//   transparent         that pixel's index equals TRANSP_INDEX
//   flash_busy          a flash is in progress (always 0 without the macro)
//
// Handshake: no backpressure exists. A pixel sampled with pix_valid=1 at
// edge N is presented with out_valid=1 after edge N+1.

module sprite_palette_bank #(
   parameter int INDEX_W      = 5,
   parameter int NUM_PAL      = 4,
   parameter int CH_W         = 4,
   parameter int TRANSP_INDEX = 0,
   localparam int PAL_W       = $clog2(NUM_PAL)
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 pix_valid,
   input  logic [PAL_W-1:0]     pal_sel,
   input  logic [INDEX_W-1:0]   index,
   input  logic                 wr_en,
   input  logic [PAL_W-1:0]     wr_pal,
   input  logic [INDEX_W-1:0]   wr_index,
   input  logic [3*CH_W-1:0]    wr_rgb,
   input  logic                 frame_tick,
   input  logic                 flash_start,
   input  logic [3:0]           flash_frames,
   output logic [CH_W-1:0]      red,
   output logic [CH_W-1:0]      green,
   output logic [CH_W-1:0]      blue,
   output logic                 out_valid,
   output logic                 transparent,
   output logic                 flash_busy
);

   localparam int ENTRIES = 2 ** INDEX_W;
   localparam int RGB_W   = 3 * CH_W;
   // Magenta key colour loaded into every entry at reset.
   localparam logic [RGB_W-1:0] KEY_RGB = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}};

   logic [RGB_W-1:0]   pal_mem [NUM_PAL][ENTRIES];

   logic               s1_valid;
   logic [PAL_W-1:0]   s1_pal;
   logic [INDEX_W-1:0] s1_index;
   logic               s1_transp;
   logic [RGB_W-1:0]   rgb_q;
   logic               flash_override;

`ifdef SPRITE_PAL_HIT_FLASH_EN
   typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} flash_state_t;

   flash_state_t state;
   logic [3:0]   frame_cnt;

   // A restart (flash_start with a non-zero length) takes precedence over
   // a frame_tick that arrives in the same cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         frame_cnt  <= 4'd0;
         flash_busy <= 1'b0;
      end else if (state == IDLE) begin
         if (flash_start && (flash_frames != 4'd0)) begin
            state      <= FLASH;
            frame_cnt  <= flash_frames;
            flash_busy <= 1'b1;
         end
      end else begin
         if (flash_start && (flash_frames != 4'd0)) begin
            frame_cnt <= flash_frames;
         end else if (frame_tick) begin
            if (frame_cnt == 4'd1) begin
               state      <= IDLE;
               frame_cnt  <= 4'd0;
               flash_busy <= 1'b0;
            end else begin
               frame_cnt <= frame_cnt - 4'd1;
            end
         end
      end
   end

   // The flash state is sampled when the pixel reaches stage 2.
   assign flash_override = flash_busy & ~s1_transp;
`else
   logic unused_flash_inputs;

   assign unused_flash_inputs = ^{frame_tick, flash_start, flash_frames};
   assign flash_busy          = 1'b0;
   assign flash_override      = 1'b0;
`endif

   // Palette storage and the two pipeline stages share one clocked block.
   // The stage-2 read uses the pre-edge contents of pal_mem. A write landing
   // on the same edge is therefore not seen until the next read (read-first).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int p = 0; p < NUM_PAL; p++) begin
            for (int i = 0; i < ENTRIES; i++) begin
               pal_mem[p][i] <= KEY_RGB;
            end
         end
         s1_valid    <= 1'b0;
         s1_pal      <= '0;
         s1_index    <= '0;
         s1_transp   <= 1'b0;
         rgb_q       <= '0;
         out_valid   <= 1'b0;
         transparent <= 1'b0;
      end else begin
         if (wr_en) begin
            pal_mem[wr_pal][wr_index] <= wr_rgb;
         end

         s1_valid  <= pix_valid;
         s1_pal    <= pal_sel;
         s1_index  <= index;
         s1_transp <= (index == INDEX_W'(TRANSP_INDEX));

         out_valid   <= s1_valid;
         transparent <= s1_valid & s1_transp;
         // While no pixel is present, the colour outputs keep their last value.
         if (s1_valid) begin
            rgb_q <= flash_override ? {RGB_W{1'b1}} : pal_mem[s1_pal][s1_index];
         end
      end
   end

   assign red   = rgb_q[RGB_W-1 -: CH_W];
   assign green = rgb_q[2*CH_W-1 -: CH_W];
   assign blue  = rgb_q[CH_W-1 -: CH_W];

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed and random bench for sprite_palette_bank. It uses the default
// parameters (INDEX_W=5, NUM_PAL=4, CH_W=4, TRANSP_INDEX=0). When
// SPRITE_PAL_HIT_FLASH_EN is defined, the bench applies the flash expectations.

module tb_sprite_palette_bank;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        pix_valid;
   logic [1:0]  pal_sel;
   logic [4:0]  index;
   logic        wr_en;
   logic [1:0]  wr_pal;
   logic [4:0]  wr_index;
   logic [11:0] wr_rgb;
   logic        frame_tick;
   logic        flash_start;
   logic [3:0]  flash_frames;
   logic [3:0]  red, green, blue;
   logic        out_valid;
   logic        transparent;
   logic        flash_busy;

   // Expected entry: {rgb_check_enable, out_valid, transparent, rgb[11:0]}
   logic [14:0] exp_q[$];
   logic [11:0] model_mem [4][32];
   logic        m_busy;
   logic [3:0]  m_cnt;
   int          errors = 0;
   int          checks = 0;

   // ---------------- clock / reset ----------------
   always #5 Clk = ~Clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   sprite_palette_bank dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .pix_valid    (pix_valid),
      .pal_sel      (pal_sel),
      .index        (index),
      .wr_en        (wr_en),
      .wr_pal       (wr_pal),
      .wr_index     (wr_index),
      .wr_rgb       (wr_rgb),
      .frame_tick   (frame_tick),
      .flash_start  (flash_start),
      .flash_frames (flash_frames),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .out_valid    (out_valid),
      .transparent  (transparent),
      .flash_busy   (flash_busy)
   );

   // ---------------- model ----------------
   task automatic model_reset();
      for (int p = 0; p < 4; p++)
         for (int i = 0; i < 32; i++)
            model_mem[p][i] = 12'hF0F;
      m_busy = 1'b0;
      m_cnt  = 4'd0;
   endtask

   task automatic clear_inputs();
      pix_valid   = 1'b0;
      wr_en       = 1'b0;
      flash_start = 1'b0;
      frame_tick  = 1'b0;
   endtask

   // ---------------- driver + scoreboard ----------------
   // Drives the current input values for one cycle. The model is updated
   // with this cycle's write and flash control, because the pixel's stage-2
   // read happens one edge later and sees both. Results are compared once
   // the two-cycle pipeline has delivered them.
   task automatic tick();
      logic [14:0] e;
      logic [11:0] col;
      if (wr_en) model_mem[wr_pal][wr_index] = wr_rgb;
`ifdef SPRITE_PAL_HIT_FLASH_EN
      if (!m_busy) begin
         if (flash_start && flash_frames != 4'd0) begin
            m_busy = 1'b1;
            m_cnt  = flash_frames;
         end
      end else if (flash_start && flash_frames != 4'd0) begin
         m_cnt = flash_frames;
      end else if (frame_tick) begin
         if (m_cnt == 4'd1) begin
            m_busy = 1'b0;
            m_cnt  = 4'd0;
         end else begin
            m_cnt = m_cnt - 4'd1;
         end
      end
`endif
      if (pix_valid) begin
         col = model_mem[pal_sel][index];
         if (m_busy && index != 5'd0) col = 12'hFFF;
         e = {1'b1, 1'b1, (index == 5'd0), col};
      end else begin
         e = 15'd0;
      end
      exp_q.push_back(e);

      @(posedge Clk);
      #1;
      checks++;
      assert (flash_busy === m_busy) else begin
         errors++;
         $error("FAIL flash_busy obs=%b exp=%b", flash_busy, m_busy);
      end
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         checks++;
         assert ({out_valid, transparent} === e[13:12]) else begin
            errors++;
            $error("FAIL vld_transp obs=%b exp=%b", {out_valid, transparent}, e[13:12]);
         end
         if (e[14]) begin
            checks++;
            assert ({red, green, blue} === e[11:0]) else begin
               errors++;
               $error("FAIL rgb obs=%h exp=%h", {red, green, blue}, e[11:0]);
            end
         end
      end
      clear_inputs();
   endtask

   task automatic pix(input logic [1:0] p, input logic [4:0] i);
      pix_valid = 1'b1;
      pal_sel   = p;
      index     = i;
   endtask

   task automatic wr(input logic [1:0] p, input logic [4:0] i, input logic [11:0] c);
      wr_en    = 1'b1;
      wr_pal   = p;
      wr_index = i;
      wr_rgb   = c;
   endtask

   // Reset is held for one cycle with a pixel and a write also presented.
   // Reset must win over both, and the pipeline must come out empty.
   task automatic do_reset();
      Reset = 1'b1;
      pix(2'd1, 5'd3);
      wr(2'd1, 5'd3, 12'h111);
      @(posedge Clk);
      #1;
      checks++;
      assert ({out_valid, transparent, red, green, blue} === 14'd0) else begin
         errors++;
         $error("FAIL reset_outs obs=%h exp=%h", {out_valid, transparent, red, green, blue}, 14'd0);
      end
      checks++;
      assert (flash_busy === 1'b0) else begin
         errors++;
         $error("FAIL reset_busy obs=%b exp=0", flash_busy);
      end
      Reset = 1'b0;
      clear_inputs();
      @(posedge Clk);
      #1;
      checks++;
      assert (out_valid === 1'b0) else begin
         errors++;
         $error("FAIL reset_flush obs=%b exp=0", out_valid);
      end
      exp_q.delete();
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Reset        = 1'b0;
      pal_sel      = '0;
      index        = '0;
      wr_pal       = '0;
      wr_index     = '0;
      wr_rgb       = '0;
      flash_frames = '0;
      clear_inputs();
      model_reset();
      @(posedge Clk);
      #1;
      do_reset();

      // Basic lookup of a reset entry: magenta key colour.
      pix(2'd0, 5'd3); tick();
      tick();

      // Write bank 1 entry 3, then look it up. Bank 0 must be unchanged.
      wr(2'd1, 5'd3, 12'h6A2); tick();
      pix(2'd1, 5'd3); tick();
      pix(2'd0, 5'd3); tick();

      // Read-first: the write lands on the edge of the first pixel's stage-2 read.
      pix(2'd2, 5'd5); tick();
      wr(2'd2, 5'd5, 12'h123); pix(2'd2, 5'd5); tick();
      pix(2'd2, 5'd5); tick();

      // Back-to-back transparent then opaque pixels.
      pix(2'd0, 5'd0); tick();
      pix(2'd3, 5'd7); tick();
      tick();

      // Hit flash of two frames. Without the macro these inputs are ignored.
      flash_start = 1'b1; flash_frames = 4'd2; pix(2'd0, 5'd7); tick();
      pix(2'd0, 5'd0); tick();
      frame_tick = 1'b1; pix(2'd1, 5'd3); tick();
      pix(2'd0, 5'd7); tick();
      frame_tick = 1'b1; pix(2'd0, 5'd7); tick();
      pix(2'd1, 5'd3); tick();

      // Restart: three frames, one tick, reload with one, then the next tick ends the flash.
      flash_start = 1'b1; flash_frames = 4'd3; tick();
      frame_tick = 1'b1; pix(2'd2, 5'd5); tick();
      flash_start = 1'b1; flash_frames = 4'd1; tick();
      pix(2'd2, 5'd5); tick();
      frame_tick = 1'b1; pix(2'd2, 5'd5); tick();

      // A zero length is ignored. Start together with a tick: the reload wins.
      flash_start = 1'b1; flash_frames = 4'd0; pix(2'd1, 5'd3); tick();
      flash_start = 1'b1; flash_frames = 4'd2; frame_tick = 1'b1; tick();
      frame_tick = 1'b1; pix(2'd1, 5'd3); tick();
      frame_tick = 1'b1; pix(2'd1, 5'd3); tick();
      pix(2'd1, 5'd3); tick();

      // Reset during a flash.
      flash_start = 1'b1; flash_frames = 4'd5; pix(2'd3, 5'd7); tick();
      pix(2'd3, 5'd7); tick();
      do_reset();
      pix(2'd1, 5'd3); tick();
      tick();

      // Random writes and lookups over a small index range, so that entries are reused.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 2) != 0)
            pix(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
         if ($urandom_range(0, 1) != 0)
            wr(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
         tick();
      end
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-bank colour lookup for sprite pixel indices. Generalises fixed single-palette ROMs.
- Holds NUM_PAL palettes of 2^INDEX_W entries each. Output is registered and pipelined, with a transparency flag aligned to each pixel.
- Sits between a sprite ROM/index stream and the VGA colour mux. Lets one sprite sheet render in several colour schemes (e.g. player 1 / player 2) and flash white on hit.

Parameters:
- INDEX_W, 5: width of the pixel colour index; 2^INDEX_W entries per palette.
- NUM_PAL, 4: number of palette banks; power of two, minimum 2.
- CH_W, 4: bits per colour channel.
- TRANSP_INDEX, 0: index value treated as transparent.
- PAL_W, $clog2(NUM_PAL): bank-select width; derived, not overridden.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  index/pal_sel valid this cycle.
- pal_sel  in  PAL_W  bank used for this pixel.
- index  in  INDEX_W  pixel colour index.
- wr_en  in  1  palette entry write strobe.
- wr_pal  in  PAL_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*CH_W  {red,green,blue} data to write.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- flash_start  in  1  begin hit-flash (HIT_FLASH_EN only).
- flash_frames  in  4  flash duration in frames (HIT_FLASH_EN only).
- red, green, blue  out  CH_W each  looked-up colour.
- out_valid  out  1  colour outputs valid.
- transparent  out  1  pixel index equalled TRANSP_INDEX.
- flash_busy  out  1  flash in progress (tied 0 without HIT_FLASH_EN).

Behaviour:
- Reset:
  - red/green/blue = 0; out_valid = 0; transparent = 0; flash_busy = 0.
  - Every palette entry loads {all-ones, 0, all-ones} (magenta key colour). Contents are therefore flop-based, not BRAM.
  - Reset takes priority over writes and lookups in the same cycle. Reset mid-stream discards both pipeline stages.
- Pipeline, latency 2:
  - Stage 1 registers pix_valid, pal_sel, index and the transparency compare.
  - Stage 2 registers the palette read and the flash override.
  - A pixel presented in cycle N appears in cycle N+2 with out_valid=1.
  - Fully pipelined: one pixel per cycle, no stalls.
  - When pix_valid=0, out_valid=0 two cycles later. RGB then holds its previous value; transparent = 0.
- Writes:
  - Single-cycle; the entry updates at the edge where wr_en=1.
  - Read-first: a lookup whose stage-2 read hits the entry being written that same cycle returns the old value. The new value is visible from the next cycle.
  - Writes are always accepted, including during a flash.
- Transparency:
  - transparent=1 iff index==TRANSP_INDEX, in any bank.
  - RGB still outputs the stored entry; the downstream mux decides what to draw.
- Widths:
  - Palette storage is NUM_PAL x 2^INDEX_W x 3*CH_W.
  - No arithmetic on colour data except the flash override.

Optional Feature:
- Macro: SPRITE_PAL_HIT_FLASH_EN.
- With the macro defined:
  - Two-state FSM, IDLE and FLASH, with a 4-bit frame counter.
  - IDLE -> FLASH on flash_start=1 with flash_frames!=0; counter loads flash_frames. flash_frames==0 is ignored.
  - In FLASH, each frame_tick decrements the counter. When a tick sees counter==1, go to IDLE.
  - flash_start while in FLASH reloads the counter (restart). Simultaneous flash_start and frame_tick: reload wins.
  - flash_busy = (state==FLASH), registered.
  - While in FLASH, stage-2 outputs all-ones RGB for valid, non-transparent pixels. Transparent pixels are unaffected.
  - The override is sampled at stage 2 of each pixel.
  - Reset returns the FSM to IDLE with counter 0.
- Without the macro: no FSM; flash_start, flash_frames and frame_tick are ignored; flash_busy is tied 0.

Test Plan:
- Reset, then index=3, pal_sel=0, pix_valid=1 -> 2 cycles later out_valid=1, RGB=F,0,F, transparent=0.
- Write bank 1 entry 3 = 0x6A2, then look up pal_sel=1 index=3 -> RGB 6,A,2. Bank 0 entry 3 still F,0,F.
- Write bank 2 entry 5 = 0x123 in the same cycle its stage-2 read occurs -> that pixel returns F,0,F; the next lookup returns 1,2,3.
- Stream index=0 then index=7 back-to-back -> transparent=1 then 0 on consecutive cycles; out_valid stays high.
- (flash) flash_start with flash_frames=2, valid index=7 -> flash_busy=1 and RGB=F,F,F; index 0 stays non-white. After 2 frame_ticks, flash_busy=0 and palette colour returns.
- (flash) flash_frames=3, one tick, then flash_start with flash_frames=1 -> the next tick ends the flash. Assert Reset during a flash -> flash_busy=0, out_valid=0 next cycle.
